// File: rtl/lia_ref_nco.sv
// lia_ref_nco: quadrature sine/cosine reference NCO with period-sync pulse.
// Optional output amplitude scaling stage: define LIA_REF_AMP_SCALE_EN.
module lia_ref_nco #(
    parameter int PHASE_W = 32,
    parameter int LUT_AW  = 8
) (
    input  logic                dac_clk_i,
    input  logic                dac_rst_i,
    input  logic                en_i,
    input  logic [PHASE_W-1:0]  ftw_i,
    input  logic                ftw_valid_i,
    output logic                ftw_ack_o,
    input  logic [PHASE_W-1:0]  phase_off_i,
    input  logic [12:0]         amp_i,
    output logic signed [13:0]  in_phase_o,
    output logic signed [13:0]  out_phase_o,
    output logic                sync_o
);
    localparam int  LUT_N   = 1 << LUT_AW;
    localparam real HALF_PI = 1.5707963267948966;

    function automatic logic [12:0] rom_val(input int k);
        return 13'($rtoi(8191.0 * $sin(HALF_PI * (real'(k) + 0.5)
                   / real'(LUT_N)) + 0.5));
    endfunction

    function automatic logic signed [13:0] signed_mag(
        input logic [12:0] r,
        input logic        neg
    );
        return neg ? -$signed({1'b0, r}) : $signed({1'b0, r});
    endfunction

    logic [12:0] rom [LUT_N];
    for (genvar k = 0; k < LUT_N; k++) begin : g_rom
        localparam logic [12:0] V = rom_val(k);
        assign rom[k] = V;
    end

    logic [PHASE_W-1:0] acc, ftw_act, ftw_pend;
    logic               pend, v0, w0, apply;
    logic [PHASE_W:0]   sum;

    assign sum = {1'b0, acc} + {1'b0, ftw_act};

    // Pending word switches only at a period boundary while running.
    always_comb begin
        apply = pend;
        if (en_i)
            apply = pend && (!v0 || sum[PHASE_W]);
    end

    always_ff @(posedge dac_clk_i or posedge dac_rst_i) begin
        if (dac_rst_i) begin
            acc <= '0;
            v0  <= 1'b0;
            w0  <= 1'b0;
        end else if (!en_i) begin
            acc <= '0;
            v0  <= 1'b0;
            w0  <= 1'b0;
        end else if (!v0) begin
            acc <= '0;
            v0  <= 1'b1;
            w0  <= 1'b1;
        end else begin
            acc <= sum[PHASE_W-1:0];
            w0  <= sum[PHASE_W];
        end
    end

    always_ff @(posedge dac_clk_i or posedge dac_rst_i) begin
        if (dac_rst_i) begin
            ftw_act   <= '0;
            ftw_pend  <= '0;
            pend      <= 1'b0;
            ftw_ack_o <= 1'b0;
        end else begin
            ftw_ack_o <= apply;
            if (apply)
                ftw_act <= ftw_pend;
            if (ftw_valid_i) begin
                ftw_pend <= ftw_i;
                pend     <= 1'b1;
            end else if (apply) begin
                pend <= 1'b0;
            end
        end
    end

    logic [LUT_AW+1:0]         ph_top, ph1;
    logic [PHASE_W-LUT_AW-3:0] ph_lsb_unused;
    logic                      v1, w1;
    logic [1:0]                q1;
    logic [LUT_AW-1:0]         i1, a_s, a_c;
    logic                      n_s2, n_c2, v2, w2;
    logic [12:0]               r_s, r_c;
    logic                      n_s3, n_c3, v3, w3;
    logic signed [13:0]        s4_i, s4_q;
    logic                      s4_sync;

    assign {ph_top, ph_lsb_unused} = acc + phase_off_i;
    assign q1 = ph1[LUT_AW+1:LUT_AW];
    assign i1 = ph1[LUT_AW-1:0];

    always_ff @(posedge dac_clk_i or posedge dac_rst_i) begin
        if (dac_rst_i || !en_i) begin
            ph1     <= '0;
            v1      <= 1'b0;
            w1      <= 1'b0;
            a_s     <= '0;
            a_c     <= '0;
            n_s2    <= 1'b0;
            n_c2    <= 1'b0;
            v2      <= 1'b0;
            w2      <= 1'b0;
            r_s     <= '0;
            r_c     <= '0;
            n_s3    <= 1'b0;
            n_c3    <= 1'b0;
            v3      <= 1'b0;
            w3      <= 1'b0;
            s4_i    <= '0;
            s4_q    <= '0;
            s4_sync <= 1'b0;
        end else begin
            ph1     <= ph_top;
            v1      <= v0;
            w1      <= w0;
            // Cosine is the next quadrant over at the same index.
            a_s     <= q1[0] ? ~i1 : i1;
            a_c     <= q1[0] ? i1 : ~i1;
            n_s2    <= q1[1];
            n_c2    <= q1[1] ^ q1[0];
            v2      <= v1;
            w2      <= w1;
            r_s     <= rom[a_s];
            r_c     <= rom[a_c];
            n_s3    <= n_s2;
            n_c3    <= n_c2;
            v3      <= v2;
            w3      <= w2;
            s4_i    <= v3 ? signed_mag(r_s, n_s3) : '0;
            s4_q    <= v3 ? signed_mag(r_c, n_c3) : '0;
            s4_sync <= v3 && w3;
        end
    end

`ifdef LIA_REF_AMP_SCALE_EN
    logic [12:0]        amp4, pi_lsb_unused, pq_lsb_unused;
    logic               pi_msb_unused, pq_msb_unused;
    logic signed [13:0] sc_i, sc_q;

    assign {pi_msb_unused, sc_i, pi_lsb_unused} =
        28'(s4_i) * 28'($signed({1'b0, amp4}));
    assign {pq_msb_unused, sc_q, pq_lsb_unused} =
        28'(s4_q) * 28'($signed({1'b0, amp4}));

    always_ff @(posedge dac_clk_i or posedge dac_rst_i) begin
        if (dac_rst_i || !en_i) begin
            amp4        <= '0;
            in_phase_o  <= '0;
            out_phase_o <= '0;
            sync_o      <= 1'b0;
        end else begin
            amp4        <= amp_i;
            in_phase_o  <= sc_i;
            out_phase_o <= sc_q;
            sync_o      <= s4_sync;
        end
    end
`else
    logic [12:0] amp_unused;

    assign amp_unused  = amp_i;
    assign in_phase_o  = s4_i;
    assign out_phase_o = s4_q;
    assign sync_o      = s4_sync;
`endif

endmodule

// File: tb/tb_lia_ref_nco.sv
// tb_lia_ref_nco: directed stimulus with an ideal sine/cosine reference
// model compared every cycle, plus hand-computed literal checks.
`timescale 1ns/1ps
module tb_lia_ref_nco;
`ifdef LIA_REF_AMP_SCALE_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 4;
`endif
    localparam int  AMP = 4096;
    localparam real PI  = 3.141592653589793;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               en = 1'b0;
    logic               ftw_valid = 1'b0;
    logic [31:0]        ftw = '0;
    logic [31:0]        off = '0;
    logic [12:0]        amp = 13'(AMP);
    logic               ack;
    logic signed [13:0] i_o, q_o;
    logic               sync;

    int n_chk = 0;
    int n_fail = 0;
    int n_ack = 0;

    always #4 clk = ~clk;

    lia_ref_nco dut (
        .dac_clk_i   (clk),
        .dac_rst_i   (rst),
        .en_i        (en),
        .ftw_i       (ftw),
        .ftw_valid_i (ftw_valid),
        .ftw_ack_o   (ack),
        .phase_off_i (off),
        .amp_i       (amp),
        .in_phase_o  (i_o),
        .out_phase_o (q_o),
        .sync_o      (sync)
    );

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    function automatic int lit(input int v);
`ifdef LIA_REF_AMP_SCALE_EN
        return (v * AMP) >>> 13;
`else
        return v;
`endif
    endfunction

    // Ideal quantised sinusoid at the centre of the 1024-step phase bin.
    function automatic int ideal(input logic [31:0] p, input bit cosine);
        real th, v;
        int  r;
        th = 2.0 * PI * (real'(p[31:22]) + 0.5) / 1024.0;
        v  = 8191.0 * (cosine ? $cos(th) : $sin(th));
        r  = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
        return lit(r);
    endfunction

    typedef struct {
        logic [31:0] acc;
        bit          wrap;
        logic [31:0] off;
    } rec_t;

    rec_t        hist[$];
    logic [31:0] m_acc = '0, m_act = '0, m_pend = '0;
    bit          m_pf = 0;
    int          m_run = 0;
    int          e_i = 0, e_q = 0;
    bit          e_sync = 0, e_ack = 0;

    always @(posedge clk or posedge rst) begin : model
        logic [32:0] sum;
        logic [31:0] nacc, nact, npend, ph;
        bit          wrap, apply, npf;
        int          nrun;
        rec_t        r;
        if (rst) begin
            m_acc  <= '0;
            m_act  <= '0;
            m_pend <= '0;
            m_pf   <= 0;
            m_run  <= 0;
            e_i    <= 0;
            e_q    <= 0;
            e_sync <= 0;
            e_ack  <= 0;
            hist.delete();
        end else begin
            wrap = 0;
            sum  = {1'b0, m_acc} + {1'b0, m_act};
            if (!en) begin
                nacc  = '0;
                apply = m_pf;
                nrun  = 0;
            end else if (m_run == 0) begin
                nacc  = '0;
                wrap  = 1;
                apply = m_pf;
                nrun  = 1;
            end else begin
                nacc  = sum[31:0];
                wrap  = sum[32];
                apply = wrap && m_pf;
                nrun  = m_run + 1;
            end
            nact  = apply ? m_pend : m_act;
            npend = ftw_valid ? ftw : m_pend;
            npf   = ftw_valid ? 1'b1 : (apply ? 1'b0 : m_pf);
            r.acc  = nacc;
            r.wrap = wrap;
            r.off  = off;
            hist.push_back(r);
            if (hist.size() > LAT + 1)
                void'(hist.pop_front());
            m_acc  <= nacc;
            m_act  <= nact;
            m_pend <= npend;
            m_pf   <= npf;
            m_run  <= nrun;
            e_ack  <= apply;
            if (nrun >= LAT + 1) begin
                ph = hist[0].acc + hist[1].off;
                e_i    <= ideal(ph, 1'b0);
                e_q    <= ideal(ph, 1'b1);
                e_sync <= hist[0].wrap;
            end else begin
                e_i    <= 0;
                e_q    <= 0;
                e_sync <= 0;
            end
        end
    end

    always @(negedge clk) begin
        check("in_phase", int'(i_o), e_i);
        check("out_phase", int'(q_o), e_q);
        check("sync", int'(sync), int'(e_sync));
        check("ftw_ack", int'(ack), int'(e_ack));
        if (ack)
            n_ack <= n_ack + 1;
    end

    task automatic wait_sync(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!sync && cyc < 2000);
        check("sync_seen", int'(sync), 1);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: no finish after 2 ms");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int c, a, mism, err, worst, l2;
        int refv[64];
        #1 rst = 1'b1;
        en = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_in", int'(i_o), 0);
        check("rst_out", int'(q_o), 0);
        check("rst_sync", int'(sync), 0);
        check("rst_ack", int'(ack), 0);
        #2 rst = 1'b0;
        for (int k = 0; k < LAT; k++) begin
            @(negedge clk);
            check("warmup_in", int'(i_o), 0);
        end
        @(negedge clk);
        check("ftw0_in", int'(i_o), lit(25));
        check("ftw0_out", int'(q_o), lit(8191));
        check("ftw0_sync", int'(sync), 1);
        @(negedge clk);
        check("ftw0_sync_once", int'(sync), 0);
        check("ftw0_in_hold", int'(i_o), lit(25));

        en = 1'b0;
        ftw = 32'h0400_0000;
        ftw_valid = 1'b1;
        @(negedge clk);
        ftw_valid = 1'b0;
        check("en_low_in", int'(i_o), 0);
        @(negedge clk);
        check("idle_load_ack", int'(ack), 1);
        en = 1'b1;
        wait_sync(c);
        check("enable_latency", c, LAT + 1);
        l2 = lit(8191) * lit(8191);
        worst = 0;
        for (int k = 0; k < 64; k++) begin
            if (k > 0)
                @(negedge clk);
            refv[k] = int'(q_o);
            err = int'(i_o) * int'(i_o) + int'(q_o) * int'(q_o) - l2;
            if (err < 0)
                err = -err;
            if (err > worst)
                worst = err;
            if (k == 0) begin
                check("p64_s0_in", int'(i_o), lit(25));
                check("p64_s0_out", int'(q_o), lit(8191));
            end
            if (k == 32) begin
                check("p64_s32_in", int'(i_o), lit(-25));
                check("p64_s32_out", int'(q_o), lit(-8191));
            end
        end
        check("norm_within_0p1pct", int'(worst * 1000 <= l2), 1);
        wait_sync(c);
        check("period64", 63 + c, 64);

        off = 32'h4000_0000;
        wait_sync(c);
        check("period64_off", c, 64);
        mism = 0;
        for (int k = 0; k < 64; k++) begin
            if (k > 0)
                @(negedge clk);
            if (int'(i_o) != refv[k])
                mism++;
        end
        check("offset_quarter_shift", mism, 0);
        off = '0;

        wait_sync(c);
        repeat (20) @(negedge clk);
        ftw = 32'h0200_0000;
        ftw_valid = 1'b1;
        @(negedge clk);
        ftw_valid = 1'b0;
        repeat (42 - LAT) @(negedge clk);
        ftw = 32'h0100_0000;
        ftw_valid = 1'b1;
        @(negedge clk);
        ftw_valid = 1'b0;
        check("ack_on_wrap", int'(ack), 1);
        wait_sync(c);
        check("ack_to_sync", c, LAT);
        a = n_ack;
        wait_sync(c);
        check("period128", c, 128);
        check("collision_ack", n_ack - a, 1);
        wait_sync(c);
        check("period256", c, 256);

        repeat (30) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        check("en_off_in", int'(i_o), 0);
        check("en_off_out", int'(q_o), 0);
        repeat (2) @(negedge clk);
        en = 1'b1;
        for (int k = 0; k < LAT; k++) begin
            @(negedge clk);
            check("reen_zero", int'(i_o), 0);
        end
        @(negedge clk);
        check("reen_sync", int'(sync), 1);
        check("reen_in", int'(i_o), lit(25));
        check("reen_out", int'(q_o), lit(8191));

        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_in", int'(i_o), 0);
        check("async_rst_out", int'(q_o), 0);
        @(negedge clk);
        #2 rst = 1'b0;
        wait_sync(c);
        check("post_rst_latency", c, LAT + 1);
        check("post_rst_out", int'(q_o), lit(8191));
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/lia_ref_nco.md
# lia_ref_nco

Quadrature reference generator for the lock-in amplifier chain. A 32-bit phase accumulator drives a quarter-wave sine ROM to produce the 14-bit in-phase (sine) and out-of-phase (cosine) references. It also produces a one-cycle period-sync pulse. All three outputs feed the lock-in amplifier's demodulator and sample accumulator directly, and share one clock domain with it.

## Interface
- `PHASE_W`, 32: phase accumulator width.
- `LUT_AW`, 8: quarter-wave ROM address width (256 entries).
- `dac_clk_i`  in  1: 125 MHz clock. The block has one clock.
- `dac_rst_i`  in  1: reset, asynchronous, active-high.
- `en_i`  in  1: run enable.
- `ftw_i`  in  PHASE_W: frequency tuning word (unsigned).
- `ftw_valid_i`  in  1: request to load `ftw_i`.
- `ftw_ack_o`  out  1: one-cycle pulse when the pending word becomes active.
- `phase_off_i`  in  PHASE_W: phase offset added before lookup. Sampled every cycle.
- `amp_i`  in  13: unsigned amplitude, 8191 ≈ 1.0. Used only with `LIA_REF_AMP_SCALE_EN`.
- `in_phase_o`  out  14 signed: sine reference.
- `out_phase_o`  out  14 signed: cosine reference.
- `sync_o`  out  1: period-start pulse, aligned with the output sample.

## Operation
- **Reset values:**
  - `acc` = 0; active FTW = 0; pending FTW = 0; pending flag = 0.
  - All outputs = 0, including `ftw_ack_o` and `sync_o`.
- **Accumulator:** each cycle with `en_i`=1, `acc <= acc + ftw_active`, modulo 2^PHASE_W.
  - The wrap flag for a sample is the carry out of that addition.
  - The first sample after `en_i` rises has `acc`=0 and wrap flag forced to 1.
- **FTW handshake:**
  - `ftw_valid_i`=1 copies `ftw_i` into the pending register and sets the pending flag. The last write wins.
  - While `en_i`=1, the pending word becomes active on the cycle the accumulator wraps. This is a phase-continuous switch at period boundaries.
  - While `en_i`=0, the pending word becomes active on the next edge.
  - `ftw_ack_o` pulses in the cycle the pending word becomes active; the pending flag then clears.
  - If `ftw_valid_i` arrives on the same edge as the apply, the new word stays pending. The old pending word is applied and acked.
- **Lookup:**
  - Phase p = `acc + phase_off_i`. Quadrant q = p[MSB:MSB-1]; index i = next LUT_AW bits.
  - ROM[k] = round(8191·sin(π/2·(k+0.5)/2^LUT_AW)). ROM[0]=25, ROM[255]=8191 (default LUT_AW).
  - Sine uses quadrant q. Cosine uses quadrant q+1 (mod 4) with the same index.
  - For odd quadrants, address the ROM at ~i. For quadrants 2 and 3, negate the ROM value.
  - Output range is ±8191. −8192 is never produced.
- **Enable low:**
  - On the first edge `en_i` is sampled 0: `acc` is cleared, all pipeline valid bits clear, and `in_phase_o`, `out_phase_o` and `sync_o` are forced to 0.
  - Re-enable restarts from phase 0 + `phase_off_i`.

## Timing
- Pipeline stages: S0 `acc`; S1 phase add and wrap-flag register; S2 quadrant/address register; S3 dual-port ROM read; S4 sign apply into the output registers.
- Latency without the macro: the sample from `acc` value A at edge n appears at edge n+4.
- `sync_o` travels in the same pipeline as its sample, so the sync pulse and the phase-0-period sample leave together.
- Outputs stay 0 until the first valid sample emerges, LAT edges after enable.
- The first valid sample always carries `sync_o`=1.
- Reset asserted mid-run clears everything asynchronously. Outputs hold 0 until re-enable plus LAT.
- Throughput: one sample per clock. There is no backpressure.

## Configuration
- `LIA_REF_AMP_SCALE_EN` defined:
  - Adds stage S5: `out = (val * amp_i) >>> 13` (arithmetic), registered. `amp_i` is sampled at S4.
  - Latency becomes 5, and `sync_o` is delayed to match.
  - `amp_i`=8191 on a value of 8191 gives 8190.
- Undefined: `amp_i` is ignored and latency is 4.

## Test plan
- **Reset and enable:** assert reset with `en_i`=1, then release. With FTW=0, after 4 cycles the outputs are constant: `in_phase_o`=25, `out_phase_o`=8191, and `sync_o` pulses once.
- **Period sync:**
  - Stimulus: FTW=2^26 (64-sample period), `phase_off_i`=0.
  - Required: `sync_o` pulses every 64 cycles.
  - Required at the sync sample: `in_phase_o`=25, `out_phase_o`=8191. At sample 32: `in_phase_o`=−25, `out_phase_o`=−8191.
  - Required over a full period: sin²+cos² stays within ±0.1% of 8191².
- **Phase offset:** FTW=2^26, `phase_off_i`=2^30 → `in_phase_o` equals the unshifted `out_phase_o` sample for sample.
- **FTW handshake:**
  - Stimulus: running with FTW=2^26, pulse `ftw_valid_i` with 2^25 mid-period.
  - Required: `ftw_ack_o` fires on the wrap edge, with no phase discontinuity.
  - Required: the next period lasts 128 cycles.
- **Same-edge collision:** a second `ftw_valid_i` (2^24) on the apply edge → 2^25 is acked and applied now; 2^24 is applied at the following wrap with its own ack.
- **Enable toggle and amplitude:**
  - Stimulus: drop `en_i` for 3 cycles mid-period.
  - Required: outputs are 0 from the next edge. After re-enable, outputs stay 0 for 4 cycles, then restart with `sync_o`.
  - With `LIA_REF_AMP_SCALE_EN` and `amp_i`=4096: peak amplitude is 4095, and latency is 5.
